fetch_stage: RTL and testbench

- IF stage of the 16-bit WISC pipeline; upstream of decode-stage branch resolution (PC control).
- Owns the architectural PC register and drives instruction-memory reads.
- Captures each fetched instruction into the IF/ID pipeline register.
- Accepts branch redirects (taken flag + target) from decode, plus stall/flush from the hazard unit; detects HLT.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 38 +++
 rtl/fetch_stage_ifid_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared WISC definitions: word width, opcodes, NOP encoding,
//               fetch-state type and the 16-bit modulo adder.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int          c_WORD_W = 16;
  localparam logic [3:0]  c_OP_ADD = 4'h0;
  localparam logic [3:0]  c_OP_HLT = 4'hF;
  // ADD R0,R0,R0 is architecturally a no-op and is used as the pipeline bubble
  localparam logic [15:0] c_NOP    = 16'h0000;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // Non-saturating 16-bit add; carry out is simply dropped
  function automatic logic [c_WORD_W-1:0] pc_add(input logic [c_WORD_W-1:0] a,
                                                 input logic [c_WORD_W-1:0] b);
    return a + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Fetch-stage bundle: instruction-memory read port, decode/
//               hazard control inputs and the IF/ID register outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;

  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic        imem_ren;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  // The fetch stage itself
  modport master (
    input  stall, redirect, redirect_pc, imem_rdata, imem_ready,
    output imem_addr, imem_ren, ifid_instr, ifid_pc, ifid_pc_plus2,
           ifid_valid, halted
  );

  // Memory, decode and hazard unit surrounding the fetch stage
  modport slave (
    output stall, redirect, redirect_pc, imem_rdata, imem_ready,
    input  imem_addr, imem_ren, ifid_instr, ifid_pc, ifid_pc_plus2,
           ifid_valid, halted
  );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ifid_reg
// Description : Generic pipeline register (instr, pc, pc+2, valid) with
//               bubble > hold > load priority; used for IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_ifid_reg #(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic             i_hold,
  input  wire logic             i_bubble,
  input  wire logic [WIDTH-1:0] i_instr,
  input  wire logic [WIDTH-1:0] i_pc,
  input  wire logic [WIDTH-1:0] i_pc_plus2,
  output logic      [WIDTH-1:0] o_instr,
  output logic      [WIDTH-1:0] o_pc,
  output logic      [WIDTH-1:0] o_pc_plus2,
  output logic                  o_valid
);

  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pc_plus2;
  logic             r_valid;

  // Bubble wins over hold so a flush can never be masked by a stall
  always_ff @(posedge clk) begin
    if (!rst_n || i_bubble) begin
      r_instr    <= WIDTH'(NOP_INSTR);
      r_pc       <= '0;
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
    end else if (i_hold) begin
      r_instr    <= r_instr;
      r_pc       <= r_pc;
      r_pc_plus2 <= r_pc_plus2;
      r_valid    <= r_valid;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus2 <= i_pc_plus2;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus2 = r_pc_plus2;
  assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : WISC IF stage: owns the PC, issues instruction-memory reads,
//               fills IF/ID, takes branch redirects and stalls, stops on HLT.
//               Optional FETCH_PERF_CNT_EN adds the fetch_count counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = c_NOP,
  parameter logic [3:0]  HLT_OPCODE = c_OP_HLT
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_e  r_state;
  logic [15:0]   r_pc;
  logic          r_halted;

  logic [15:0]   w_redirect_pc;
  logic [15:0]   w_pc_plus2;
  logic          w_is_hlt;
  logic          w_run;
  logic          w_load;
  logic          w_bubble;
  logic          w_fetch;

  // Targets are halfword aligned; bit 0 of the branch target is ignored
  assign w_redirect_pc = bus.redirect_pc & 16'hFFFE;
  assign w_pc_plus2    = pc_add(r_pc, 16'd2);
  assign w_is_hlt      = (bus.imem_rdata[15:12] == HLT_OPCODE);
  assign w_run         = (r_state == ST_RUN);
  assign w_load        = w_run & bus.imem_ready;
  // Redirect flushes; otherwise an unstalled cycle without fresh data is a bubble
  assign w_bubble      = bus.redirect | (~bus.stall & ~w_load);
  assign w_fetch       = ~bus.redirect & ~bus.stall & w_load;

  // PC and RUN/HALTED control: reset > redirect > stall > fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (bus.redirect) begin
      r_pc     <= w_redirect_pc;
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (bus.stall) begin
      r_pc     <= r_pc;
    end else if (w_load) begin
      if (w_is_hlt) begin
        r_state  <= ST_HALTED;
        r_halted <= 1'b1;
      end else begin
        r_pc     <= w_pc_plus2;
      end
    end
  end

  fetch_stage_ifid_reg #(
    .WIDTH     (c_WORD_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_hold     (bus.stall),
    .i_bubble   (w_bubble),
    .i_instr    (bus.imem_rdata),
    .i_pc       (r_pc),
    .i_pc_plus2 (w_pc_plus2),
    .o_instr    (bus.ifid_instr),
    .o_pc       (bus.ifid_pc),
    .o_pc_plus2 (bus.ifid_pc_plus2),
    .o_valid    (bus.ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  // Counts every edge that loads a valid instruction into IF/ID
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_fetch) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

  // No request while held in reset or once halted
  assign bus.imem_ren  = rst_n & w_run;
  assign bus.imem_addr = r_pc;
  assign bus.halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] w_fetch_count;
`endif

  fetch_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (w_fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pc, input logic [15:0] pc2,
                            input logic valid);
    check_eq({tag, ".instr"}, 32'(bus.ifid_instr), 32'(instr));
    check_eq({tag, ".pc"},    32'(bus.ifid_pc),    32'(pc));
    check_eq({tag, ".plus2"}, 32'(bus.ifid_pc_plus2), 32'(pc2));
    check_eq({tag, ".valid"}, 32'(bus.ifid_valid), 32'(valid));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.imem_rdata  = 16'h0000;
    bus.imem_ready  = 1'b0;

    // Reset state
    step();
    step();
    check_eq("rst.addr",   32'(bus.imem_addr), 32'h0000);
    check_eq("rst.ren",    32'(bus.imem_ren),  32'h0);
    check_eq("rst.halted", 32'(bus.halted),    32'h0);
    check_ifid("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    #1;
    check_eq("run.ren", 32'(bus.imem_ren), 32'h1);

    // Back-to-back fetches
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'h1234;
    step();
    check_eq("f1.addr", 32'(bus.imem_addr), 32'h0002);
    check_ifid("f1", 16'h1234, 16'h0000, 16'h0002, 1'b1);
    bus.imem_rdata = 16'h5678;
    step();
    check_eq("f2.addr", 32'(bus.imem_addr), 32'h0004);
    check_ifid("f2", 16'h5678, 16'h0002, 16'h0004, 1'b1);

    // Memory wait states at pc=4
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("wait.addr",  32'(bus.imem_addr),  32'h0004);
      check_eq("wait.valid", 32'(bus.ifid_valid), 32'h0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'hABCD;
    step();
    check_eq("wait.done.addr", 32'(bus.imem_addr), 32'h0006);
    check_ifid("wait.done", 16'hABCD, 16'h0004, 16'h0006, 1'b1);

    // Stall with ready data that must be dropped
    bus.stall      = 1'b1;
    bus.imem_rdata = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stall.addr", 32'(bus.imem_addr), 32'h0006);
      check_ifid("stall", 16'hABCD, 16'h0004, 16'h0006, 1'b1);
    end
    bus.stall      = 1'b0;
    bus.imem_rdata = 16'h2222;
    step();
    check_eq("unstall.addr", 32'(bus.imem_addr), 32'h0008);
    check_ifid("unstall", 16'h2222, 16'h0006, 16'h0008, 1'b1);

    // HLT at pc=8
    bus.imem_rdata = 16'hF000;
    step();
    check_ifid("hlt", 16'hF000, 16'h0008, 16'h000A, 1'b1);
    check_eq("hlt.halted", 32'(bus.halted),    32'h1);
    check_eq("hlt.ren",    32'(bus.imem_ren),  32'h0);
    check_eq("hlt.addr",   32'(bus.imem_addr), 32'h0008);
    bus.imem_rdata = 16'h7777;
    step();
    check_eq("hlt2.addr",   32'(bus.imem_addr),  32'h0008);
    check_eq("hlt2.valid",  32'(bus.ifid_valid), 32'h0);
    check_eq("hlt2.halted", 32'(bus.halted),     32'h1);

    // Redirect out of HALTED
    bus.imem_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0020;
    step();
    check_eq("unhalt.halted", 32'(bus.halted),     32'h0);
    check_eq("unhalt.addr",   32'(bus.imem_addr),  32'h0020);
    check_eq("unhalt.ren",    32'(bus.imem_ren),   32'h1);
    check_eq("unhalt.valid",  32'(bus.ifid_valid), 32'h0);
    bus.redirect   = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'h3333;
    step();
    check_eq("resume.addr", 32'(bus.imem_addr), 32'h0022);
    check_ifid("resume", 16'h3333, 16'h0020, 16'h0022, 1'b1);

    // Redirect beats stall; ready data discarded; bit 0 forced low
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0101;
    bus.stall       = 1'b1;
    bus.imem_rdata  = 16'h4444;
    step();
    check_eq("redir.addr", 32'(bus.imem_addr), 32'h0100);
    check_ifid("redir", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    bus.redirect   = 1'b0;
    bus.stall      = 1'b0;
    bus.imem_rdata = 16'h5555;
    step();
    check_ifid("redir.first", 16'h5555, 16'h0100, 16'h0102, 1'b1);

    // PC wrap at 0xFFFE
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect   = 1'b0;
    bus.imem_rdata = 16'h6666;
    step();
    check_eq("wrap.addr", 32'(bus.imem_addr), 32'h0000);
    check_ifid("wrap", 16'h6666, 16'hFFFE, 16'h0000, 1'b1);

    // Reset while halted
    bus.imem_rdata = 16'hF123;
    step();
    check_eq("hlt3.halted", 32'(bus.halted), 32'h1);
    bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("rst2.halted", 32'(bus.halted),     32'h0);
    check_eq("rst2.addr",   32'(bus.imem_addr),  32'h0000);
    check_eq("rst2.valid",  32'(bus.ifid_valid), 32'h0);
    check_eq("rst2.ren",    32'(bus.imem_ren),   32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("rst2.ren.run", 32'(bus.imem_ren), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
